// File: rtl/led_fader.sv
// led_fader: turns level edges into linear brightness ramps driving a PWM LED pin; level_i -> busy_o takes 2 cycles, no backpressure.
// Define LED_FADER_GAMMA_EN to load PWM duty from a squared (gamma) brightness curve.
module led_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 49_000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                level_i,
    output logic                pwm_o,
    output logic [PWM_BITS-1:0] bright_o,
    output logic                busy_o
);
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam int                  SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t              state_q, state_d;
    logic                level_q;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_src;
    logic                pwm_q;
    logic                tick;
    logic                ramping;

    assign ramping = (state_q == S_UP) || (state_q == S_DOWN);
    assign tick    = (step_cnt_q == STEP_LAST);

    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        case (state_q)
            S_OFF: begin
                if (level_q) state_d = S_UP;
            end
            S_UP: begin
                // Saturating step: a DOWN->UP reversal at MAX must not wrap.
                if (tick) bright_d = (bright_q == MAX) ? MAX : bright_q + 1'b1;
                if (tick && (bright_d == MAX)) state_d = S_ON;
                else if (!level_q)             state_d = S_DOWN;
            end
            S_ON: begin
                if (!level_q) state_d = S_DOWN;
            end
            S_DOWN: begin
                if (tick) bright_d = (bright_q == '0) ? '0 : bright_q - 1'b1;
                if (tick && (bright_d == '0)) state_d = S_OFF;
                else if (level_q)             state_d = S_UP;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        if ((state_d != state_q) || !ramping || tick) step_cnt_d = '0;
        else                                          step_cnt_d = step_cnt_q + 1'b1;
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] bright_sq;
    assign bright_sq = (2*PWM_BITS)'(bright_q) * (2*PWM_BITS)'(bright_q);
    assign duty_src  = (bright_q == MAX) ? MAX : bright_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_src  = bright_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            level_q    <= 1'b0;
            state_q    <= S_OFF;
            bright_q   <= '0;
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
        end else begin
            level_q    <= level_i;
            state_q    <= state_d;
            bright_q   <= bright_d;
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            // Duty only moves at the period boundary so a period is never split.
            if (pwm_cnt_q == MAX) duty_q <= duty_src;
            pwm_q      <= (duty_q == MAX) || (pwm_cnt_q < duty_q);
        end
    end

    assign pwm_o    = pwm_q;
    assign bright_o = bright_q;
    assign busy_o   = ramping;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader (PWM_BITS=4, STEP_DIV=2) against an integer ramp/PWM reference model.
module tb_led_fader;
    localparam int W    = 4;
    localparam int DIV  = 2;
    localparam int MAXV = 15;
    localparam int P    = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         level = 1'b0;
    logic         pwm;
    logic [W-1:0] bright;
    logic         busy;

    always #5 clk = ~clk;

    led_fader #(.PWM_BITS(W), .STEP_DIV(DIV)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .level_i  (level),
        .pwm_o    (pwm),
        .bright_o (bright),
        .busy_o   (busy)
    );

    typedef struct {
        int bright;
        int busy;
        int pwm;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    // Reference model: brightness as an integer moving in direction m_dir
    // (+1 fading in, -1 fading out, 0 at rest), stepping every DIV cycles.
    int m_lvl, m_bright, m_dir, m_age, m_cyc, m_duty, m_pwm;

    function automatic int gamma_f(input int b);
`ifdef LED_FADER_GAMMA_EN
        if (b == MAXV) return MAXV;
        return (b * b) >> W;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, n_cyc, act, exp);
        end
    endtask

    task automatic step_model(input bit rst, input bit lvl);
        int want, nb;
        bit reached;
        if (!rst) begin
            m_lvl = 0; m_bright = 0; m_dir = 0; m_age = 0;
            m_cyc = 0; m_duty = 0; m_pwm = 0;
            return;
        end
        m_pwm = (m_duty == MAXV) || ((m_cyc % P) < m_duty);
        if (m_cyc == MAXV) m_duty = gamma_f(m_bright);
        m_cyc = (m_cyc + 1) % P;
        want = m_lvl ? 1 : -1;
        if (m_dir == 0) begin
            if (m_bright == 0 && want == 1) begin
                m_dir = 1; m_age = 0;
            end else if (m_bright == MAXV && want == -1) begin
                m_dir = -1; m_age = 0;
            end
        end else begin
            reached = 0;
            if (m_age == DIV - 1) begin
                nb = m_bright + m_dir;
                if (nb > MAXV) nb = MAXV;
                if (nb < 0) nb = 0;
                m_bright = nb;
                m_age = 0;
                reached = (m_dir == 1) ? (m_bright == MAXV) : (m_bright == 0);
            end else begin
                m_age++;
            end
            if (reached) begin
                m_dir = 0; m_age = 0;
            end else if (want != m_dir) begin
                m_dir = want; m_age = 0;
            end
        end
        m_lvl = lvl;
    endtask

    task automatic cyc(input bit rst, input bit lvl);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        level = lvl;
        step_model(rst, lvl);
        e.bright = m_bright;
        e.busy   = (m_dir != 0) ? 1 : 0;
        e.pwm    = m_pwm;
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (sb_q.size() > 0) begin
                e_mon = sb_q.pop_front();
                chk("bright_o", 32'(bright), 32'(e_mon.bright));
                chk("busy_o",   32'(busy),   32'(e_mon.busy));
                chk("pwm_o",    32'(pwm),    32'(e_mon.pwm));
            end
        end
    end

    int guard;
    int hits;
    int hold;
    bit lv;

    initial begin
        // Reset held with level high: everything must stay at zero.
        repeat (5) cyc(0, 1);
        // Full fade in, then rest at MAX long enough for constant-on PWM.
        repeat (50) cyc(1, 1);
        // Full fade out to OFF.
        repeat (50) cyc(1, 0);
        // Mid-ramp reversal around bright=6.
        guard = 0;
        while (m_bright < 6 && guard < 100) begin
            cyc(1, 1);
            guard++;
        end
        repeat (24) cyc(1, 0);
        // Fade in and freeze at 9 by reversing every cycle right before the 9th step lands.
        guard = 0;
        while (!(m_bright == 8 && m_age == 1 && m_dir == 1) && guard < 100) begin
            cyc(1, 1);
            guard++;
        end
        hits = 0;
        for (int i = 0; i < 96; i++) begin
            cyc(1, (i % 2) == 1);
            if (i >= 64 && pwm === 1'b1) hits++;
        end
        chk("frozen_bright", 32'(bright), 32'd9);
        chk("duty9_high_cycles_2_periods", 32'(hits), 32'(2 * gamma_f(9)));
        // Randomized level runs with occasional reset pulses.
        for (int k = 0; k < 70; k++) begin
            hold = $urandom_range(1, 40);
            lv   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) repeat ($urandom_range(1, 3)) cyc(0, lv);
            repeat (hold) cyc(1, lv);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream consumer of the blink/level stage. Takes its 1-bit LED level and drives the physical LED pin with a PWM signal.
- Each edge of the level is turned into a linear brightness ramp (fade in / fade out) instead of a hard step.
- Single clock domain, same clock as the level source. Sits between the blink logic and the board pin.

Parameters:
- PWM_BITS, 8: width of the PWM counter and the brightness value; MAX = 2^PWM_BITS-1.
- STEP_DIV, 49_000: clock cycles per brightness step; full ramp = MAX*STEP_DIV cycles (about 0.5 s at 25 MHz). Legal range ≥1.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  synchronous reset, active-low.
- level_i  input  1  requested LED level from the upstream blink stage (1 = on).
- pwm_o  output  1  PWM drive to the LED pin.
- bright_o  output  PWM_BITS  current brightness.
- busy_o  output  1  high while ramping (states UP/DOWN).

Behaviour:
- Reset is synchronous and active-low, sampled only on the rising edge of clk_i. While rst_n_i=0:
  - state=OFF; level_q, bright, duty, pwm_cnt and step_cnt = 0.
  - pwm_o=0, bright_o=0, busy_o=0.
  - Reset asserted mid-ramp aborts the ramp immediately; no fade out.
- Input register: level_q <= level_i every cycle. The FSM uses only level_q, giving 1 cycle input latency.
- FSM, evaluated every cycle:
  - OFF (bright=0): level_q=1 -> UP.
  - UP: on each step tick bright <= bright+1. Tick that makes bright=MAX -> ON. level_q=0 -> DOWN, keeping the current bright (no jump). If the tick and level_q=0 occur in the same cycle, the tick is applied and the next state is DOWN, unless bright reached MAX, in which case next state is ON.
  - ON (bright=MAX): level_q=0 -> DOWN.
  - DOWN: on each tick bright <= bright-1. Tick that makes bright=0 -> OFF. level_q=1 -> UP, keeping bright. Same-cycle rule mirrors UP (reaching 0 gives OFF).
- Step prescaler:
  - step_cnt counts 0..STEP_DIV-1 only in UP/DOWN and is cleared to 0 on any state change.
  - Tick = (step_cnt==STEP_DIV-1), after which step_cnt wraps to 0.
  - First step lands STEP_DIV cycles after entering UP/DOWN.
  - STEP_DIV=1 gives a tick every cycle in UP/DOWN.
- bright never wraps: saturates at 0 and MAX by construction of the FSM.
- bright_o = bright, registered. busy_o = (state==UP or DOWN), registered with the state.
- PWM:
  - pwm_cnt is free-running PWM_BITS wide and wraps MAX->0.
  - duty <= bright only in the cycle pwm_cnt==MAX, so duty changes only at period boundaries (glitch-free).
  - pwm_o <= 1 if duty==MAX; otherwise pwm_o <= (pwm_cnt < duty).
  - duty=0 gives constant 0; duty=MAX gives constant 1. High time per 2^PWM_BITS-cycle period is exactly duty cycles (MAX forced fully on).
- Latency: level_i edge -> busy_o change is 2 cycles.
- Arithmetic is all unsigned. Comparisons are PWM_BITS wide. step_cnt width = $clog2(STEP_DIV) (min 1).

Optional Feature:
- Macro: LED_FADER_GAMMA_EN.
- Defined:
  - duty is loaded from gamma(bright) = (bright*bright) >> PWM_BITS, using a 2*PWM_BITS-bit product, except bright==MAX maps to MAX.
  - This gives a perceptually linear fade. bright_o still reports linear bright.
  - Product is computed combinationally and latched at the same pwm_cnt==MAX point.
- Undefined: duty <= bright directly, with no multiplier synthesized.

Test Plan:
- Reset: hold rst_n_i=0 for 5 cycles with level_i=1 -> pwm_o=0, bright_o=0, busy_o=0 throughout; release -> busy_o rises 2 cycles later.
- Full ramp up (PWM_BITS=4, STEP_DIV=2): level_i 0->1 and held -> bright_o steps 1..15 every 2 cycles; bright_o=15 and busy_o=0 exactly 30 cycles after busy_o rose; pwm_o then constant 1 after the next pwm_cnt wrap.
- Full ramp down from ON (same params): level_i 1->0 -> bright_o 15..0 over 30 cycles; state OFF; pwm_o constant 0 from the first period after duty=0.
- Mid-ramp reversal: level_i=1 until bright_o=6, then 0 -> no jump; next value 5, reaching 0 after 6 ticks; busy_o stays high with no gap at reversal.
- PWM duty check (gamma off): force bright=9 by holding the ramp, then level_i low long enough to stop at 9 via reversal timing -> exactly 9 high cycles per 16-cycle period, duty changes only at the pwm_cnt=15->0 boundary.
- Gamma on (LED_FADER_GAMMA_EN, PWM_BITS=8): bright 128 -> duty 64; bright 255 -> pwm_o constant 1; bright 15 -> duty 0, so pwm_o stays low.
